prbs8_checker: RTL and testbench

- Serial receive-side checker for the team's 8-bit Fibonacci LFSR pattern generator.
- The generator's state update is s <= {s[0]^s[2]^s[5]^s[6], s[7:1]}, with init seed 8'h80 and serial output s[0] on each clock.
- This block takes that bit stream, self-synchronises to it, and then predicts every following bit. It flags mismatches, counts errors and checked bits, and drops lock after sustained errors.
- It sits at the far end of a link or loopback path under test, opposite the generator.

---
 rtl/prbs8_checker.sv | 177 +++++++++++++++++
 tb/tb_prbs8_checker.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs8_checker.sv
// ---------------------------------------------------------------------------
// prbs8_checker
//
// Receive-side checker for the 8-bit Fibonacci LFSR pattern generator
// (s <= {s[0]^s[2]^s[5]^s[6], s[7:1]}, serial output s[0]).
//
// The block first collects 8 valid bits into a history register. If that
// history is nonzero, it locks. After locking it predicts each following bit
// from the recurrence b_k = b_{k-8}^b_{k-6}^b_{k-3}^b_{k-2}. A mismatch raises
// a one-cycle err pulse and bumps a saturating error counter. Lock is dropped
// after LOSS_THRESH consecutive mismatches.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   din       in   received serial bit
//   din_valid in   din is sampled only when high; otherwise all state holds
//   clr_cnt   in   synchronous clear of err_cnt / chk_cnt (wins over increment)
//   locked    out  high while in CHECK state
//   err       out  registered one-cycle mismatch pulse
//   err_cnt   out  saturating mismatch count
//   chk_cnt   out  saturating count of bits compared while locked
//   hist      out  history register, hist[0] is the newest bit
// ---------------------------------------------------------------------------
module prbs8_checker #(
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [7:0]       hist
);

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [3:0]       THRESH  = 4'(LOSS_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [3:0]       consec_q, consec_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic [CNT_W-1:0] chkCnt_q, chkCnt_d;

  logic             predBit;
  logic             mismatch;
  logic [3:0]       consecInc;
  logic             errInc;
  logic             chkInc;

  // The taps line up with the recurrence: hist[7] is b_{k-8}, hist[5] is
  // b_{k-6}, hist[2] is b_{k-3} and hist[1] is b_{k-2}.
  assign predBit   = hist_q[7] ^ hist_q[5] ^ hist_q[2] ^ hist_q[1];
  assign mismatch  = din ^ predBit;
  assign consecInc = consec_q + 4'd1;

  // Next-state logic for the sync/check state machine and the history
  // register. On a mismatch, the predicted bit is shifted in instead of the
  // received bit. This flywheel keeps the prediction on the true sequence,
  // so one corrupted bit produces only one error.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    consec_d = consec_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    errInc   = 1'b0;
    chkInc   = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        SYNC: begin
          hist_d = {hist_q[6:0], din};
          if (fill_q == 4'd7) begin
            // An all-zero window cannot come from a running generator, so
            // keep searching rather than lock onto it.
            fill_d = 4'd0;
            if (hist_d != 8'h00) begin
              state_d  = CHECK;
              locked_d = 1'b1;
            end
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end

        CHECK: begin
          chkInc = 1'b1;
          if (!mismatch) begin
            hist_d   = {hist_q[6:0], din};
            consec_d = 4'd0;
          end else begin
            hist_d = {hist_q[6:0], predBit};
            err_d  = 1'b1;
            errInc = 1'b1;
            if (consecInc == THRESH) begin
              state_d  = SYNC;
              locked_d = 1'b0;
              fill_d   = 4'd0;
              consec_d = 4'd0;
            end else begin
              consec_d = consecInc;
            end
          end
        end

        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  // Saturating counters. A clear in the same cycle wins, so the event of
  // that cycle is dropped rather than counted.
  always_comb begin
    errCnt_d = errCnt_q;
    chkCnt_d = chkCnt_q;
    if (clr_cnt) begin
      errCnt_d = '0;
      chkCnt_d = '0;
    end else begin
      if (errInc && (errCnt_q != CNT_MAX)) begin
        errCnt_d = errCnt_q + CNT_ONE;
      end
      if (chkInc && (chkCnt_q != CNT_MAX)) begin
        chkCnt_d = chkCnt_q + CNT_ONE;
      end
    end
  end

  // All state, including the registered outputs, updates here. Reset clears
  // everything immediately, so the link must resynchronise from scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SYNC;
      hist_q   <= 8'h00;
      fill_q   <= 4'd0;
      consec_q <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
      chkCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      consec_q <= consec_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
      chkCnt_q <= chkCnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = errCnt_q;
  assign chk_cnt = chkCnt_q;
  assign hist    = hist_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs8_checker
//
// Bench for prbs8_checker. It drives two instances from the same stimulus:
// one with 16-bit counters and one with 4-bit counters to exercise
// saturation. It first steps through a hand-derived vector table. It then
// runs generator-driven scenarios whose expectations come from a queue-based
// model of the received bit stream.
// ---------------------------------------------------------------------------
module tb_prbs8_checker;

  logic        clock;
  logic        reset;
  logic        din;
  logic        dinValid;
  logic        clrCnt;
  logic        locked;
  logic        err;
  logic [15:0] errCnt;
  logic [15:0] chkCnt;
  logic [7:0]  hist;
  logic        satLocked;
  logic        satErr;
  logic [3:0]  satErrCnt;
  logic [3:0]  satChkCnt;
  logic [7:0]  satHist;

  int total = 0;
  int bad   = 0;
  int errPulses = 0;

  prbs8_checker #(.CNT_W(16), .LOSS_THRESH(4)) dut (
    .clk(clock), .rst(reset), .din(din), .din_valid(dinValid),
    .clr_cnt(clrCnt), .locked(locked), .err(err), .err_cnt(errCnt),
    .chk_cnt(chkCnt), .hist(hist)
  );

  prbs8_checker #(.CNT_W(4), .LOSS_THRESH(4)) dutSat (
    .clk(clock), .rst(reset), .din(din), .din_valid(dinValid),
    .clr_cnt(clrCnt), .locked(satLocked), .err(satErr), .err_cnt(satErrCnt),
    .chk_cnt(satChkCnt), .hist(satHist)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ------------------------------------------------------------------------
  // Transmit-side generator, seed 8'h80
  // ------------------------------------------------------------------------
  bit [7:0] genS;

  task automatic genBit(output bit b);
    b    = genS[0];
    genS = {genS[0] ^ genS[2] ^ genS[5] ^ genS[6], genS[7:1]};
  endtask

  // ------------------------------------------------------------------------
  // Reference model: a queue of the 8 most recently accepted bits (oldest
  // first), a lock flag, plus integer counters with explicit saturation.
  // ------------------------------------------------------------------------
  bit mq[$];
  bit mLocked;
  bit mErr;
  int mFill;
  int mConsec;
  int mErrCnt, mChkCnt, mSatErrCnt, mSatChkCnt;

  function automatic int satAdd(input int v, input int maxV);
    return (v >= maxV) ? maxV : v + 1;
  endfunction

  task automatic modelReset();
    mq = {};
    for (int i = 0; i < 8; i++) mq.push_back(1'b0);
    mLocked = 0; mErr = 0; mFill = 0; mConsec = 0;
    mErrCnt = 0; mChkCnt = 0; mSatErrCnt = 0; mSatChkCnt = 0;
  endtask

  function automatic logic [7:0] modelHist();
    logic [7:0] h;
    for (int i = 0; i < 8; i++) h[i] = mq[7 - i];
    return h;
  endfunction

  task automatic modelStep(input bit d, input bit v, input bit c);
    bit pred;
    bit anyOne;
    bit errEvt = 0;
    bit chkEvt = 0;
    mErr = 0;
    if (v) begin
      if (!mLocked) begin
        mq.push_back(d);
        void'(mq.pop_front());
        mFill++;
        if (mFill == 8) begin
          mFill = 0;
          anyOne = 0;
          foreach (mq[i]) anyOne |= mq[i];
          if (anyOne) mLocked = 1;
        end
      end else begin
        // b_k = b_{k-8} ^ b_{k-6} ^ b_{k-3} ^ b_{k-2}, queue index 0 is b_{k-8}
        pred   = mq[0] ^ mq[2] ^ mq[5] ^ mq[6];
        chkEvt = 1;
        if (d == pred) begin
          mq.push_back(d);
          mConsec = 0;
        end else begin
          mq.push_back(pred);
          mErr = 1;
          errEvt = 1;
          mConsec++;
          if (mConsec == 4) begin
            mLocked = 0; mFill = 0; mConsec = 0;
          end
        end
        void'(mq.pop_front());
      end
    end
    if (c) begin
      mErrCnt = 0; mChkCnt = 0; mSatErrCnt = 0; mSatChkCnt = 0;
    end else begin
      if (errEvt) begin
        mErrCnt = satAdd(mErrCnt, 65535);
        mSatErrCnt = satAdd(mSatErrCnt, 15);
      end
      if (chkEvt) begin
        mChkCnt = satAdd(mChkCnt, 65535);
        mSatChkCnt = satAdd(mSatChkCnt, 15);
      end
    end
  endtask

  // ------------------------------------------------------------------------
  // Drive / check helpers
  // ------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, let the DUT sample on the
  // rising edge, then advance the model and leave outputs to settle.
  task automatic applyStimulus(input bit d, input bit v, input bit c);
    @(negedge clock);
    din = d; dinValid = v; clrCnt = c;
    @(posedge clock);
    #1;
    modelStep(d, v, c);
    if (err === 1'b1) errPulses++;
  endtask

  task automatic checkModel();
    checkOutput("locked", locked, mLocked);
    checkOutput("err", err, mErr);
    checkOutput("errCnt", errCnt, mErrCnt);
    checkOutput("chkCnt", chkCnt, mChkCnt);
    checkOutput("hist", hist, modelHist());
    checkOutput("satErrCnt", satErrCnt, mSatErrCnt);
    checkOutput("satChkCnt", satChkCnt, mSatChkCnt);
  endtask

  task automatic driveBit(input bit d, input bit v, input bit c);
    applyStimulus(d, v, c);
    checkModel();
  endtask

  task automatic feedGen(input int n, input bit invert);
    bit b;
    for (int i = 0; i < n; i++) begin
      genBit(b);
      driveBit(b ^ invert, 1'b1, 1'b0);
    end
  endtask

  task automatic doReset();
    din = 0; dinValid = 0; clrCnt = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    genS = 8'h80;
    errPulses = 0;
  endtask

  // ------------------------------------------------------------------------
  // Directed vector table: stream from seed 8'h80 is
  // 0,0,0,0,0,0,0,1, 0,1,1,1,0,1,1,1 ...
  // ------------------------------------------------------------------------
  typedef struct {
    bit         d;
    bit         v;
    bit         c;
    bit         expLocked;
    bit         expErr;
    int         expErrCnt;
    int         expChkCnt;
    logic [7:0] expHist;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int validChecked;
    bit b;
    bit v;

    reset = 1'b1; din = 0; dinValid = 0; clrCnt = 0;
    genS = 8'h80;
    modelReset();

    // Rows 0-7 fill the window; row 9 and row 15 are bubbles. Row 11 is a
    // corrupted b10. Rows 12-13 clear the counters; row 13 also mismatches.
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[3]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[4]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[5]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[6]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00};
    vecs[7]  = '{1, 1, 0, 1, 0, 0, 0, 8'h01};
    vecs[8]  = '{0, 1, 0, 1, 0, 0, 1, 8'h02};
    vecs[9]  = '{1, 0, 0, 1, 0, 0, 1, 8'h02};
    vecs[10] = '{1, 1, 0, 1, 0, 0, 2, 8'h05};
    vecs[11] = '{0, 1, 0, 1, 1, 1, 3, 8'h0B};
    vecs[12] = '{1, 1, 1, 1, 0, 0, 0, 8'h17};
    vecs[13] = '{1, 1, 1, 1, 1, 0, 0, 8'h2E};
    vecs[14] = '{1, 1, 0, 1, 0, 0, 1, 8'h5D};
    vecs[15] = '{1, 0, 0, 1, 0, 0, 1, 8'h5D};

    // Reset values while reset is held.
    #12;
    checkOutput("rstLocked", locked, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstErrCnt", errCnt, 0);
    checkOutput("rstChkCnt", chkCnt, 0);
    checkOutput("rstHist", hist, 0);

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].v, vecs[i].c);
      checkOutput($sformatf("vec%0d.locked", i), locked, vecs[i].expLocked);
      checkOutput($sformatf("vec%0d.err", i), err, vecs[i].expErr);
      checkOutput($sformatf("vec%0d.errCnt", i), errCnt, vecs[i].expErrCnt);
      checkOutput($sformatf("vec%0d.chkCnt", i), chkCnt, vecs[i].expChkCnt);
      checkOutput($sformatf("vec%0d.hist", i), hist, vecs[i].expHist);
      checkOutput($sformatf("vec%0d.satErrCnt", i), satErrCnt, vecs[i].expErrCnt);
    end

    // Lock and clean check.
    doReset();
    feedGen(8, 0);
    checkOutput("cleanLock", locked, 1);
    feedGen(100, 0);
    checkOutput("cleanChkCnt", chkCnt, 100);
    checkOutput("cleanErrCnt", errCnt, 0);
    checkOutput("cleanErrPulses", errPulses, 0);

    // Single-bit error on the 20th bit of the next block.
    feedGen(19, 0);
    feedGen(1, 1);
    feedGen(20, 0);
    checkOutput("singleErrCnt", errCnt, 1);
    checkOutput("singleErrPulses", errPulses, 1);
    checkOutput("singleLocked", locked, 1);

    // Loss of lock after 4 consecutive errors, then re-lock.
    driveBit(1'b0, 1'b0, 1'b1);
    errPulses = 0;
    feedGen(4, 1);
    checkOutput("lossErrCnt", errCnt, 4);
    checkOutput("lossErrPulses", errPulses, 4);
    checkOutput("lossLocked", locked, 0);
    feedGen(8, 0);
    checkOutput("relockLocked", locked, 1);
    checkOutput("relockErrCnt", errCnt, 4);

    // All-zero input never locks.
    doReset();
    for (int i = 0; i < 24; i++) driveBit(1'b0, 1'b1, 1'b0);
    checkOutput("zeroLocked", locked, 0);
    checkOutput("zeroErrPulses", errPulses, 0);
    checkOutput("zeroChkCnt", chkCnt, 0);

    // Clean stream with random valid bubbles.
    doReset();
    feedGen(8, 0);
    validChecked = 0;
    for (int i = 0; i < 150; i++) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) begin
        genBit(b);
        validChecked++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      driveBit(b, v, 1'b0);
    end
    checkOutput("bubbleChkCnt", chkCnt, validChecked);
    checkOutput("bubbleErrCnt", errCnt, 0);

    // Saturation: 20 isolated errors.
    doReset();
    feedGen(8, 0);
    for (int i = 0; i < 20; i++) begin
      feedGen(5, 0);
      feedGen(1, 1);
    end
    checkOutput("satWideErrCnt", errCnt, 20);
    checkOutput("satNarrowErrCnt", satErrCnt, 15);
    checkOutput("satNarrowChkCnt", satChkCnt, 15);
    checkOutput("satLocked", locked, 1);

    // Asynchronous reset in the middle of CHECK.
    @(negedge clock);
    dinValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncLocked", locked, 0);
    checkOutput("asyncErrCnt", errCnt, 0);
    checkOutput("asyncChkCnt", chkCnt, 0);
    checkOutput("asyncHist", hist, 0);
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    feedGen(7, 0);
    checkOutput("asyncNotYet", locked, 0);
    feedGen(1, 0);
    checkOutput("asyncRelock", locked, 1);

    // Random mix of bubbles, corrupted bits and clears against the model.
    doReset();
    feedGen(8, 0);
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        genBit(b);
        if ($urandom_range(0, 11) == 0) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      driveBit(b, v, ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
